vn_bus_controller: RTL and testbench
====================================

VN_BUS_CONTROLLER -- requirements
Module: vn_bus_controller

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL provide parameter DATA_W, default 16, memory/instruction data width.
REQ-003 SHALL provide parameter CNT_W, default 16, fetch counter width.
REQ-004 SHALL provide parameter TIMEOUT, default 15, max consecutive not-ready access cycles; 0 = timeout disabled.
REQ-005 SHALL use one clock; reset is asynchronous and active-low; ports named clock and reset.
REQ-006 clock  in  1  system clock, all state on rising edge.
REQ-007 reset  in  1  asynchronous active-low reset.
REQ-008 fetch_req  in  1  datapath requests instruction fetch at pc_addr.
REQ-009 pc_addr  in  ADDR_W  instruction address.
REQ-010 data_req  in  1  datapath requests load/store.
REQ-011 data_we  in  1  1 = store, 0 = load.
REQ-012 data_addr  in  ADDR_W  data address from ALU.
REQ-013 data_wdata  in  DATA_W  store data from register file.
REQ-014 halt_in  in  1  halt request from control unit.
REQ-015 resume  in  1  leave HALTED.
REQ-016 mem_req / mem_we  out  1 / 1  memory request, write strobe.
REQ-017 mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address, write data.
REQ-018 mem_rdata / mem_ready  in  DATA_W / 1  read data, access-complete.
REQ-019 instr, instr_valid  out  DATA_W, 1  fetched instruction, one-cycle pulse.
REQ-020 load_data, load_valid  out  DATA_W, 1  loaded word, one-cycle pulse.
REQ-021 store_done  out  1  one-cycle pulse, store complete.
REQ-022 busy / halted / bus_error  out  1 / 1 / 1  access in flight / in HALTED / sticky timeout flag.
REQ-023 fetch_count  out  CNT_W  completed fetches.

Function
REQ-024 FSM states SHALL be IDLE, FETCH, DATA, HALTED; all outputs registered.
REQ-025 In IDLE, priority SHALL be: halt_in -> HALTED; else data_req -> DATA; else fetch_req -> FETCH; else stay.
REQ-026 On entering FETCH/DATA, address, we, wdata SHALL be captured and held stable on mem_* with mem_req=1 until mem_ready sampled high.
REQ-027 mem_we SHALL be 1 only in DATA with captured data_we=1; mem_wdata SHALL be 0 outside stores.
REQ-028 Access SHALL complete on the edge where mem_req=1 and mem_ready=1; mem_req deasserts and state returns to IDLE (or HALTED if halt pending) on that edge.
REQ-029 Fetch completion SHALL register mem_rdata into instr and pulse instr_valid for one cycle; instr holds until next fetch.
REQ-030 Load completion SHALL register load_data and pulse load_valid; store completion SHALL pulse store_done.
REQ-031 Zero-wait memory SHALL give 2 cycles per access: accept edge N, complete edge N+1, valid during cycle after N+1.
REQ-032 halt_in during FETCH/DATA SHALL set a pending flag; access completes normally, then HALTED.
REQ-033 In HALTED, mem_req=0, halted=1; all requests ignored; resume=1 -> IDLE and clears bus_error; halt_in and resume together SHALL keep HALTED.
REQ-034 Wait counter SHALL count consecutive mem_req=1 cycles with mem_ready=0; at TIMEOUT (nonzero) abort: mem_req=0, bus_error=1, no valid pulse, state HALTED.
REQ-035 fetch_count SHALL increment per completed fetch, wrap 2^CNT_W-1 -> 0.
REQ-036 busy SHALL equal 1 exactly in FETCH/DATA; mem_ready outside FETCH/DATA ignored.

Reset
REQ-037 reset=0 SHALL immediately force IDLE, all outputs 0, instr=0, load_data=0, fetch_count=0, pending halt and wait counter cleared, including mid-access (mem_req drops asynchronously).

Verification
REQ-038 Zero-wait fetch: pc_addr=0x10, fetch_req=1, mem_ready=1, mem_rdata=0xABCD -> mem_req one cycle at 0x10, instr=0xABCD, instr_valid one cycle, fetch_count=1.
REQ-039 Priority: fetch_req and data_req (store 0x1234 to 0x20) same cycle -> store first (mem_we=1, store_done), then fetch.
REQ-040 Wait states: load at 0x05, mem_ready low 3 cycles -> mem_addr/mem_req stable 4 cycles, load_valid once, load_data=mem_rdata.
REQ-041 Timeout: TIMEOUT=15, mem_ready held 0 -> abort after 15 wait cycles, bus_error=1, halted=1; resume -> IDLE, bus_error=0.
REQ-042 Halt mid-access: halt_in pulse during 2-wait fetch -> fetch completes, instr_valid pulses, then halted=1, further fetch_req ignored.
REQ-043 Reset mid-access and wrap: reset=0 during DATA -> mem_req=0 immediately; CNT_W=4, 16 fetches -> fetch_count returns to 0.

Source files
------------

// File: rtl/vn_bus_controller.sv
// ---------------------------------------------------------------------------
// vn_bus_controller
//
// Single-port memory bus controller for a von Neumann datapath. Instruction
// fetches and data loads/stores share one memory port; this block arbitrates
// between them, holds the request stable until the memory reports ready,
// returns fetched/loaded words as one-cycle pulses, and supervises the bus
// with a wait-state timeout that parks the machine in HALTED.
//
// Ports
//   clock       in   system clock, all state on rising edge
//   reset       in   asynchronous active-low reset
//   fetch_req   in   datapath requests instruction fetch at pc_addr
//   pc_addr     in   instruction address
//   data_req    in   datapath requests load/store
//   data_we     in   1 = store, 0 = load
//   data_addr   in   data address
//   data_wdata  in   store data
//   halt_in     in   halt request from control unit
//   resume      in   leave HALTED
//   mem_req     out  memory request, held until mem_ready sampled high
//   mem_we      out  memory write strobe (stores only)
//   mem_addr    out  memory address
//   mem_wdata   out  memory write data (zero unless storing)
//   mem_rdata   in   memory read data
//   mem_ready   in   memory access complete
//   instr       out  last fetched instruction
//   instr_valid out  one-cycle pulse, instr updated
//   load_data   out  last loaded word
//   load_valid  out  one-cycle pulse, load_data updated
//   store_done  out  one-cycle pulse, store complete
//   busy        out  access in flight (FETCH or DATA)
//   halted      out  controller is in HALTED
//   bus_error   out  sticky timeout flag, cleared by resume
//   fetch_count out  completed fetches, wraps
// ---------------------------------------------------------------------------
module vn_bus_controller #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic              halt_in,
    input  logic              resume,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              store_done,
    output logic              busy,
    output logic              halted,
    output logic              bus_error,
    output logic [CNT_W-1:0]  fetch_count
);

    // Wait counter only needs to reach TIMEOUT-1; keep at least one bit so
    // the declaration stays legal when the timeout is disabled or tiny.
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DATA   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t            state;
    logic              halt_pend;
    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            halt_pend   <= 1'b0;
            wait_cnt    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            load_data   <= '0;
            load_valid  <= 1'b0;
            store_done  <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            bus_error   <= 1'b0;
            fetch_count <= '0;
        end else begin
            // Completion strobes are single-cycle by default.
            instr_valid <= 1'b0;
            load_valid  <= 1'b0;
            store_done  <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Halt beats data, data beats fetch: a pending load/store
                    // must land before the next instruction is fetched.
                    if (halt_in) begin
                        state  <= S_HALTED;
                        halted <= 1'b1;
                    end else if (data_req) begin
                        state     <= S_DATA;
                        busy      <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= data_we;
                        mem_addr  <= data_addr;
                        mem_wdata <= data_we ? data_wdata : '0;
                        wait_cnt  <= '0;
                    end else if (fetch_req) begin
                        state     <= S_FETCH;
                        busy      <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= pc_addr;
                        mem_wdata <= '0;
                        wait_cnt  <= '0;
                    end
                end

                S_FETCH, S_DATA: begin
                    if (mem_ready) begin
                        // Access completes on this edge; drop the bus.
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        busy      <= 1'b0;
                        wait_cnt  <= '0;
                        halt_pend <= 1'b0;

                        if (state == S_FETCH) begin
                            instr       <= mem_rdata;
                            instr_valid <= 1'b1;
                            fetch_count <= fetch_count + 1'b1;
                        end else if (mem_we) begin
                            store_done <= 1'b1;
                        end else begin
                            load_data  <= mem_rdata;
                            load_valid <= 1'b1;
                        end

                        // A halt raised on the completing edge itself is
                        // honoured as if it had been latched earlier.
                        if (halt_pend || halt_in) begin
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
                        // TIMEOUT consecutive not-ready cycles: abandon the
                        // access without any completion pulse.
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        busy      <= 1'b0;
                        wait_cnt  <= '0;
                        halt_pend <= 1'b0;
                        bus_error <= 1'b1;
                        state     <= S_HALTED;
                        halted    <= 1'b1;
                    end else begin
                        if (TIMEOUT != 0)
                            wait_cnt <= wait_cnt + 1'b1;
                        if (halt_in)
                            halt_pend <= 1'b1;
                    end
                end

                S_HALTED: begin
                    // halt_in wins over resume so a held halt keeps us parked.
                    if (resume && !halt_in) begin
                        state     <= S_IDLE;
                        halted    <= 1'b0;
                        bus_error <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vn_bus_controller.sv
// ---------------------------------------------------------------------------
// tb_vn_bus_controller
//
// Directed self-checking bench for vn_bus_controller. Inputs are driven and
// outputs sampled 1 time unit after each rising edge. The DUT is built with
// CNT_W=4 so fetch_count wrap is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_vn_bus_controller;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 15;

    logic              clock;
    logic              reset;
    logic              fetch_req;
    logic [ADDR_W-1:0] pc_addr;
    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              halt_in;
    logic              resume;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              store_done;
    logic              busy;
    logic              halted;
    logic              bus_error;
    logic [CNT_W-1:0]  fetch_count;

    int passed = 0;
    int total  = 0;

    vn_bus_controller #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .pc_addr    (pc_addr),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .halt_in    (halt_in),
        .resume     (resume),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .instr      (instr),
        .instr_valid(instr_valid),
        .load_data  (load_data),
        .load_valid (load_valid),
        .store_done (store_done),
        .busy       (busy),
        .halted     (halted),
        .bus_error  (bus_error),
        .fetch_count(fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; fetch_req = 1'b0; pc_addr = '0; data_req = 1'b0;
        data_we = 1'b0; data_addr = '0; data_wdata = '0; halt_in = 1'b0;
        resume = 1'b0; mem_rdata = '0; mem_ready = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_mem_req",   32'(mem_req),     32'h0);
        chk("rst_mem_we",    32'(mem_we),      32'h0);
        chk("rst_mem_addr",  32'(mem_addr),    32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata),   32'h0);
        chk("rst_instr",     32'(instr),       32'h0);
        chk("rst_load_data", 32'(load_data),   32'h0);
        chk("rst_busy",      32'(busy),        32'h0);
        chk("rst_halted",    32'(halted),      32'h0);
        chk("rst_bus_error", 32'(bus_error),   32'h0);
        chk("rst_fcount",    32'(fetch_count), 32'h0);
        reset = 1'b1;
        tick();

        // ---------------- zero-wait fetch ----------------
        pc_addr = 8'h10; fetch_req = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hABCD;
        tick();                                   // accept edge
        fetch_req = 1'b0;
        chk("zw_mem_req",  32'(mem_req),  32'h1);
        chk("zw_mem_addr", 32'(mem_addr), 32'h10);
        chk("zw_mem_we",   32'(mem_we),   32'h0);
        chk("zw_busy",     32'(busy),     32'h1);
        chk("zw_ivalid0",  32'(instr_valid), 32'h0);
        tick();                                   // complete edge
        chk("zw_req_drop", 32'(mem_req),     32'h0);
        chk("zw_ivalid",   32'(instr_valid), 32'h1);
        chk("zw_instr",    32'(instr),       32'hABCD);
        chk("zw_fcount",   32'(fetch_count), 32'h1);
        chk("zw_busy_off", 32'(busy),        32'h0);
        tick();
        chk("zw_ivalid_pulse", 32'(instr_valid), 32'h0);
        chk("zw_instr_hold",   32'(instr),       32'hABCD);
        chk("zw_idle_noreq",   32'(mem_req),     32'h0);

        // ---------------- priority: store before fetch ----------------
        fetch_req = 1'b1; pc_addr = 8'h11; data_req = 1'b1; data_we = 1'b1;
        data_addr = 8'h20; data_wdata = 16'h1234; mem_rdata = 16'h5555;
        tick();
        data_req = 1'b0;
        chk("pr_mem_we",    32'(mem_we),    32'h1);
        chk("pr_mem_addr",  32'(mem_addr),  32'h20);
        chk("pr_mem_wdata", 32'(mem_wdata), 32'h1234);
        tick();
        chk("pr_store_done", 32'(store_done), 32'h1);
        chk("pr_req_drop",   32'(mem_req),    32'h0);
        chk("pr_no_ivalid",  32'(instr_valid), 32'h0);
        tick();                                   // fetch accepted now
        fetch_req = 1'b0;
        chk("pr_f_addr",   32'(mem_addr),   32'h11);
        chk("pr_f_we",     32'(mem_we),     32'h0);
        chk("pr_f_wdata",  32'(mem_wdata),  32'h0);
        chk("pr_sd_pulse", 32'(store_done), 32'h0);
        tick();
        chk("pr_f_instr",  32'(instr),       32'h5555);
        chk("pr_f_ivalid", 32'(instr_valid), 32'h1);
        chk("pr_f_fcount", 32'(fetch_count), 32'h2);
        data_we = 1'b0;

        // ---------------- load with 3 wait states ----------------
        data_req = 1'b1; data_addr = 8'h05; mem_ready = 1'b0; mem_rdata = 16'hBEEF;
        tick();
        data_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ws_req_%0d", i),  32'(mem_req),    32'h1);
            chk($sformatf("ws_addr_%0d", i), 32'(mem_addr),   32'h05);
            chk($sformatf("ws_lv_%0d", i),   32'(load_valid), 32'h0);
            tick();
        end
        chk("ws_req_3",  32'(mem_req),  32'h1);
        chk("ws_addr_3", 32'(mem_addr), 32'h05);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("ws_lvalid", 32'(load_valid), 32'h1);
        chk("ws_ldata",  32'(load_data),  32'hBEEF);
        chk("ws_drop",   32'(mem_req),    32'h0);
        tick();
        chk("ws_lv_pulse", 32'(load_valid), 32'h0);

        // ---------------- timeout ----------------
        fetch_req = 1'b1; pc_addr = 8'h30; mem_ready = 1'b0;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            chk($sformatf("to_req_%0d", i), 32'(mem_req),   32'h1);
            chk($sformatf("to_err_%0d", i), 32'(bus_error), 32'h0);
            tick();
        end
        chk("to_req_drop", 32'(mem_req),     32'h0);
        chk("to_bus_err",  32'(bus_error),   32'h1);
        chk("to_halted",   32'(halted),      32'h1);
        chk("to_no_valid", 32'(instr_valid), 32'h0);
        chk("to_fcount",   32'(fetch_count), 32'h2);
        fetch_req = 1'b1; mem_ready = 1'b1;
        tick();
        chk("to_ign_req",  32'(mem_req), 32'h0);
        chk("to_ign_halt", 32'(halted),  32'h1);
        fetch_req = 1'b0; halt_in = 1'b1; resume = 1'b1;
        tick();
        chk("to_both_halted", 32'(halted),    32'h1);
        chk("to_both_err",    32'(bus_error), 32'h1);
        halt_in = 1'b0;
        tick();
        resume = 1'b0;
        chk("to_resume_halted", 32'(halted),    32'h0);
        chk("to_resume_err",    32'(bus_error), 32'h0);

        // ---------------- halt during a 2-wait fetch ----------------
        fetch_req = 1'b1; pc_addr = 8'h40; mem_ready = 1'b0; mem_rdata = 16'h7777;
        tick();
        fetch_req = 1'b0; halt_in = 1'b1;
        tick();                                   // wait 1, halt latched
        halt_in = 1'b0;
        chk("hm_req",     32'(mem_req), 32'h1);
        chk("hm_not_yet", 32'(halted),  32'h0);
        tick();                                   // wait 2
        mem_ready = 1'b1;
        tick();
        chk("hm_ivalid", 32'(instr_valid), 32'h1);
        chk("hm_instr",  32'(instr),       32'h7777);
        chk("hm_halted", 32'(halted),      32'h1);
        chk("hm_fcount", 32'(fetch_count), 32'h3);
        fetch_req = 1'b1;
        tick();
        chk("hm_ign_req", 32'(mem_req), 32'h0);
        tick();
        chk("hm_ign_fcount", 32'(fetch_count), 32'h3);
        fetch_req = 1'b0; resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("hm_resumed", 32'(halted), 32'h0);

        // ---------------- asynchronous reset mid-access ----------------
        data_req = 1'b1; data_we = 1'b1; data_addr = 8'h50; data_wdata = 16'hAAAA;
        mem_ready = 1'b0;
        tick();
        data_req = 1'b0;
        chk("ar_req_before", 32'(mem_req), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("ar_req_async",  32'(mem_req),     32'h0);
        chk("ar_we_async",   32'(mem_we),      32'h0);
        chk("ar_busy_async", 32'(busy),        32'h0);
        chk("ar_fcount",     32'(fetch_count), 32'h0);
        chk("ar_instr",      32'(instr),       32'h0);
        data_we = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("ar_idle", 32'(mem_req), 32'h0);

        // ---------------- fetch_count wrap (CNT_W=4) ----------------
        mem_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            fetch_req = 1'b1; pc_addr = 8'(i); mem_rdata = 16'(16'h100 + i);
            tick();
            fetch_req = 1'b0;
            tick();
            chk($sformatf("wr_instr_%0d", i),  32'(instr),       32'(16'h100 + i));
            chk($sformatf("wr_fcount_%0d", i), 32'(fetch_count), 32'((i + 1) % 16));
        end
        mem_ready = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
